// File: rtl/sata_rx_prim_dec.sv
// sata_rx_prim_dec: receive-side SATA dword classifier. Recognises primitives,
// swallows ALIGN, expands CONT streams into repeats of the last primitive,
// forwards data dwords and counts coding errors. One-cycle registered latency.
module sata_rx_prim_dec #(
  parameter int unsigned C_ERR_CNT_W        = 16,
  parameter int unsigned C_HOLD_ON_LINKDOWN = 0
) (
  input  logic                   clk_75m,
  input  logic                   host_rst,
  input  logic                   link_up,
  input  logic [31:0]            rxdata_fis,
  input  logic [3:0]             rxcharisk,
  output logic [31:0]            rx_dword,
  output logic                   rx_valid,
  output logic                   rx_is_prim,
  output logic [4:0]             rx_prim,
  output logic                   cont_active,
  output logic                   align_det,
  output logic                   code_err,
  output logic [C_ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned PW      = 5;
  localparam int unsigned N_PRIMS = 18;

  localparam logic [PW-1:0] P_ALIGN   = PW'(0);
  localparam logic [PW-1:0] P_CONT    = PW'(1);
  localparam logic [PW-1:0] P_UNKNOWN = PW'(31);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_CONT   = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] last_prim;
  logic          last_valid;

  logic [PW-1:0] dec_code;
  logic          k_none;
  logic          k_prim;
  logic          is_align;
  logic          is_cont;
  logic          is_other_prim;
  logic          is_illegal;

  // 32-bit wire value of each primitive code
  function automatic logic [31:0] prim_value(input logic [PW-1:0] code);
    case (code)
      5'd0:    prim_value = 32'h7B4A4ABC; // ALIGN
      5'd1:    prim_value = 32'h9999AA7C; // CONT
      5'd2:    prim_value = 32'h3636B57C; // DMAT
      5'd3:    prim_value = 32'hD5D5B57C; // EOF
      5'd4:    prim_value = 32'hD5D5AA7C; // HOLD
      5'd5:    prim_value = 32'h9595AA7C; // HOLDA
      5'd6:    prim_value = 32'h9595957C; // PMACK
      5'd7:    prim_value = 32'hF5F5957C; // PMNAK
      5'd8:    prim_value = 32'h1717B57C; // PMREQ_P
      5'd9:    prim_value = 32'h7575957C; // PMREQ_S
      5'd10:   prim_value = 32'h5656B57C; // R_ERR
      5'd11:   prim_value = 32'h5555B57C; // R_IP
      5'd12:   prim_value = 32'h3535B57C; // R_OK
      5'd13:   prim_value = 32'h4A4A957C; // R_RDY
      5'd14:   prim_value = 32'h3737B57C; // SOF
      5'd15:   prim_value = 32'hB5B5957C; // SYNC
      5'd16:   prim_value = 32'h5858B57C; // WTRM
      5'd17:   prim_value = 32'h5757B57C; // X_RDY
      default: prim_value = 32'h00000000;
    endcase
  endfunction

  // Classify the incoming dword against the primitive table
  always_comb begin
    k_none   = (rxcharisk == 4'b0000);
    k_prim   = (rxcharisk == 4'b0001);
    dec_code = P_UNKNOWN;
    if (k_prim) begin
      for (int unsigned i = 0; i < N_PRIMS; i++) begin
        if (rxdata_fis == prim_value(PW'(i))) dec_code = PW'(i);
      end
    end
    is_align      = k_prim && (dec_code == P_ALIGN);
    is_cont       = k_prim && (dec_code == P_CONT);
    is_other_prim = k_prim && (dec_code != P_UNKNOWN) && !is_align && !is_cont;
    is_illegal    = (!k_none && !k_prim) ||
                    (k_prim && (dec_code == P_UNKNOWN)) ||
                    (is_cont && !last_valid);
  end

  // Decoder state, last-primitive memory and registered outputs
  always_ff @(posedge clk_75m or posedge host_rst) begin
    if (host_rst) begin
      state       <= ST_NORMAL;
      last_prim   <= '0;
      last_valid  <= 1'b0;
      rx_dword    <= '0;
      rx_valid    <= 1'b0;
      rx_is_prim  <= 1'b0;
      rx_prim     <= '0;
      cont_active <= 1'b0;
      align_det   <= 1'b0;
      code_err    <= 1'b0;
      err_cnt     <= '0;
    end else begin
      rx_dword   <= '0;
      rx_valid   <= 1'b0;
      rx_is_prim <= 1'b0;
      rx_prim    <= '0;
      align_det  <= 1'b0;
      code_err   <= 1'b0;
      if (!link_up) begin
        state       <= ST_NORMAL;
        last_prim   <= '0;
        last_valid  <= 1'b0;
        cont_active <= 1'b0;
        if (C_HOLD_ON_LINKDOWN == 0) err_cnt <= '0;
      end else if (is_illegal) begin
        // state untouched; count saturates at all-ones
        code_err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + C_ERR_CNT_W'(1);
      end else if (is_align) begin
        align_det <= 1'b1;
      end else if (is_cont) begin
        rx_valid    <= 1'b1;
        rx_is_prim  <= 1'b1;
        rx_prim     <= last_prim;
        rx_dword    <= prim_value(last_prim);
        state       <= ST_CONT;
        cont_active <= 1'b1;
      end else if (is_other_prim) begin
        rx_valid    <= 1'b1;
        rx_is_prim  <= 1'b1;
        rx_prim     <= dec_code;
        rx_dword    <= rxdata_fis;
        last_prim   <= dec_code;
        last_valid  <= 1'b1;
        state       <= ST_NORMAL;
        cont_active <= 1'b0;
      end else if (state == ST_CONT) begin
        // scrambled filler: repeat the held primitive, drop the payload
        rx_valid   <= 1'b1;
        rx_is_prim <= 1'b1;
        rx_prim    <= last_prim;
        rx_dword   <= prim_value(last_prim);
      end else begin
        rx_valid <= 1'b1;
        rx_dword <= rxdata_fis;
      end
    end
  end

endmodule

// File: tb/tb_sata_rx_prim_dec.sv
// Directed bench for sata_rx_prim_dec with an expected-result queue.
module tb_sata_rx_prim_dec;

  localparam int unsigned CW = 4;

  localparam logic [31:0] TBL [18] = '{
    32'h7B4A4ABC, 32'h9999AA7C, 32'h3636B57C, 32'hD5D5B57C, 32'hD5D5AA7C,
    32'h9595AA7C, 32'h9595957C, 32'hF5F5957C, 32'h1717B57C, 32'h7575957C,
    32'h5656B57C, 32'h5555B57C, 32'h3535B57C, 32'h4A4A957C, 32'h3737B57C,
    32'hB5B5957C, 32'h5858B57C, 32'h5757B57C
  };

  logic          clk_75m = 1'b0;
  logic          host_rst;
  logic          link_up;
  logic [31:0]   rxdata_fis;
  logic [3:0]    rxcharisk;
  logic [31:0]   rx_dword;
  logic          rx_valid;
  logic          rx_is_prim;
  logic [4:0]    rx_prim;
  logic          cont_active;
  logic          align_det;
  logic          code_err;
  logic [CW-1:0] err_cnt;

  always #5 clk_75m = ~clk_75m;

  sata_rx_prim_dec #(.C_ERR_CNT_W(CW), .C_HOLD_ON_LINKDOWN(0)) dut (
    .clk_75m(clk_75m), .host_rst(host_rst), .link_up(link_up),
    .rxdata_fis(rxdata_fis), .rxcharisk(rxcharisk),
    .rx_dword(rx_dword), .rx_valid(rx_valid), .rx_is_prim(rx_is_prim),
    .rx_prim(rx_prim), .cont_active(cont_active), .align_det(align_det),
    .code_err(code_err), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic          valid;
    logic          is_prim;
    logic [4:0]    prim;
    logic [31:0]   dword;
    logic          cont;
    logic          align;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          exp_cont = 1'b0;

  function automatic exp_t mk(input logic v, input logic ip, input int code,
                              input logic [31:0] dw, input logic al, input logic er);
    exp_t e;
    e.valid = v; e.is_prim = ip; e.prim = 5'(code); e.dword = dw;
    e.cont = exp_cont; e.align = al; e.err = er; e.cnt = exp_cnt;
    return e;
  endfunction

  // Pop one expectation and compare; fields that carry no meaning are masked
  task automatic check(input string tag, input bit full);
    exp_t e;
    exp_t o;
    e = sb_q.pop_front();
    o = {rx_valid, rx_is_prim, rx_prim, rx_dword, cont_active, align_det, code_err, err_cnt};
    if (!full) begin
      if (!e.valid) begin
        o.is_prim = e.is_prim; o.prim = e.prim; o.dword = e.dword;
      end else if (!e.is_prim) begin
        o.prim = e.prim;
      end
    end
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed v=%0b p=%0b prim=%0d dw=%h cont=%0b al=%0b err=%0b cnt=%0d required v=%0b p=%0b prim=%0d dw=%h cont=%0b al=%0b err=%0b cnt=%0d",
             tag, o.valid, o.is_prim, o.prim, o.dword, o.cont, o.align, o.err, o.cnt,
             e.valid, e.is_prim, e.prim, e.dword, e.cont, e.align, e.err, e.cnt);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] d, input logic [3:0] k,
                      input exp_t e, input bit full = 1'b0);
    rxdata_fis = d;
    rxcharisk  = k;
    sb_q.push_back(e);
    @(posedge clk_75m);
    #1;
    check(tag, full);
  endtask

  task automatic send_prim(input string tag, input int code);
    exp_cont = 1'b0;
    step(tag, TBL[code], 4'b0001, mk(1'b1, 1'b1, code, TBL[code], 1'b0, 1'b0));
  endtask

  task automatic send_cont(input string tag, input int last);
    exp_cont = 1'b1;
    step(tag, TBL[1], 4'b0001, mk(1'b1, 1'b1, last, TBL[last], 1'b0, 1'b0));
  endtask

  task automatic send_fill(input string tag, input int last);
    step(tag, $urandom, 4'b0000, mk(1'b1, 1'b1, last, TBL[last], 1'b0, 1'b0));
  endtask

  task automatic send_data(input string tag, input logic [31:0] d);
    step(tag, d, 4'b0000, mk(1'b1, 1'b0, 0, d, 1'b0, 1'b0));
  endtask

  task automatic send_align(input string tag);
    step(tag, TBL[0], 4'b0001, mk(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0));
  endtask

  task automatic send_err(input string tag, input logic [31:0] d, input logic [3:0] k);
    if (exp_cnt != '1) exp_cnt = exp_cnt + CW'(1);
    step(tag, d, k, mk(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1));
  endtask

  task automatic check_zero(input string tag);
    sb_q.push_back(exp_t'(0));
    check(tag, 1'b1);
  endtask

  initial begin
    host_rst   = 1'b1;
    link_up    = 1'b0;
    rxdata_fis = '0;
    rxcharisk  = '0;
    repeat (2) @(posedge clk_75m);
    #1;
    check_zero("reset");
    host_rst = 1'b0;

    // link down: random input must be ignored
    for (int i = 0; i < 20; i++) begin
      step("idle", $urandom, 4'($urandom_range(0, 15)), exp_t'(0), 1'b1);
    end

    link_up = 1'b1;
    // decode sweep
    send_align("sweep_align");
    for (int c = 2; c < 18; c++) send_prim("sweep_prim", c);
    send_cont("sweep_cont", 17);
    send_prim("sweep_sync", 15);

    // CONT expansion
    send_prim("hold0", 4);
    send_prim("hold1", 4);
    send_cont("cont", 4);
    for (int i = 0; i < 5; i++) send_fill("fill_a", 4);
    send_align("align_in_cont");
    for (int i = 0; i < 2; i++) send_fill("fill_b", 4);
    send_prim("r_ip_exit", 11);

    // same-code primitive also leaves CONT
    send_prim("hold2", 4);
    send_cont("cont2", 4);
    send_prim("hold_exit", 4);

    // data passthrough
    send_prim("sof", 14);
    send_data("data0", 32'h12345678);
    send_data("data1", 32'hDEADBEEF);

    // asynchronous reset while in CONT
    send_prim("sync_pre_rst", 15);
    send_cont("cont_pre_rst", 15);
    #2 host_rst = 1'b1;
    #1;
    check_zero("rst_mid_cont");
    exp_cnt  = '0;
    exp_cont = 1'b0;
    @(posedge clk_75m);
    #1 host_rst = 1'b0;

    // coding errors
    send_err("cont_no_last", TBL[1], 4'b0001);
    send_err("bad_k", 32'h0000_00BC, 4'b0010);
    send_err("unknown_prim", 32'h0000_007C, 4'b0001);
    send_prim("sync_e", 15);
    send_cont("cont_e", 15);
    send_err("unknown_in_cont", 32'h0000_007C, 4'b0001);
    for (int i = 0; i < 20; i++) send_err("saturate", $urandom, 4'b1111);
    send_fill("fill_after_err", 15);

    // link drop while in CONT
    link_up  = 1'b0;
    exp_cont = 1'b0;
    exp_cnt  = '0;
    step("link_drop", $urandom, 4'b0000, mk(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0));
    link_up = 1'b1;
    send_err("cont_after_drop", TBL[1], 4'b0001);
    send_data("data_after_drop", 32'hCAFE0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sata_rx_prim_dec.md
Name: sata_rx_prim_dec

Overview:
- Receive-side dword classifier between the GTX receive path (rxdata_fis/rxcharisk) and the link-layer state machine.
- Counterpart of the transmit primitive/CONT generation feeding txdata_fis/tx_charisk_fis.
- Recognises SATA primitives and drops ALIGN.
- Expands CONT streams: holds the last primitive and discards scrambled filler. Passes data dwords through. Flags coding errors.

Parameters:
C_ERR_CNT_W, 16, width of saturating error counter
C_HOLD_ON_LINKDOWN, 0, 1 = keep err_cnt across link_up drop; 0 = clear it on link_up low

Ports:
clk_75m  input  1  phy clock (phyclk); all logic rising edge
host_rst  input  1  asynchronous, active-high reset
link_up  input  1  OOB complete; low forces the decoder idle
rxdata_fis  input  32  received dword, byte0 in [7:0]
rxcharisk  input  4  K flags per byte
rx_dword  output  32  registered dword (data, or 32-bit primitive value)
rx_valid  output  1  rx_dword/rx_prim valid this cycle
rx_is_prim  output  1  qualifies rx_valid: 1 = primitive, 0 = data
rx_prim  output  5  primitive code, valid when rx_is_prim
cont_active  output  1  decoder in CONT state
align_det  output  1  one-cycle pulse per ALIGN received
code_err  output  1  one-cycle pulse on illegal dword
err_cnt  output  C_ERR_CNT_W  saturating count of code_err pulses

Behaviour:
- Reset (host_rst high, async): all outputs 0; state NORMAL; last_prim cleared (invalid).
- Latency: exactly 1 clk_75m cycle from input dword to registered output.
- A dword is a candidate primitive when rxcharisk==4'b0001 and rxdata_fis[7:0] is 8'h7C or 8'hBC.
- Primitive codes:
  - 0 ALIGN 7B4A4ABC
  - 1 CONT 9999AA7C
  - 2 DMAT 3636B57C
  - 3 EOF D5D5B57C
  - 4 HOLD D5D5AA7C
  - 5 HOLDA 9595AA7C
  - 6 PMACK 9595957C
  - 7 PMNAK F5F5957C
  - 8 PMREQ_P 1717B57C
  - 9 PMREQ_S 7575957C
  - 10 R_ERR 5656B57C
  - 11 R_IP 5555B57C
  - 12 R_OK 3535B57C
  - 13 R_RDY 4A4A957C
  - 14 SOF 3737B57C
  - 15 SYNC B5B5957C
  - 16 WTRM 5858B57C
  - 17 X_RDY 5757B57C
  - 31 UNKNOWN
- Illegal dword (code_err pulse, err_cnt+1 saturating at all-ones) when any of:
  - rxcharisk not in {0000, 0001};
  - rxcharisk==0001 but the dword matches no table entry;
  - CONT received while last_prim is invalid.
- Illegal dword output handling: rx_valid=0, and state is unchanged.
- ALIGN, any state:
  - align_det=1 and rx_valid=0;
  - state and last_prim unchanged (ALIGN never terminates CONT).
- State NORMAL:
  - Data dword (charisk 0000): rx_valid=1, rx_is_prim=0, rx_dword=input.
  - Legal primitive other than ALIGN/CONT: rx_valid=1, rx_is_prim=1, rx_prim=code, rx_dword=input; last_prim<=code.
  - CONT with last_prim valid: go to CONT_ACTIVE. Output is rx_valid=1 with the repeated last_prim (rx_prim=last_prim, rx_dword=its table value).
- State CONT_ACTIVE (cont_active=1):
  - Each non-ALIGN data dword (scrambled filler) outputs rx_valid=1, rx_is_prim=1, rx_prim=last_prim. The filler itself is never forwarded.
  - Additional CONT: same output, stay in CONT_ACTIVE.
  - New legal primitive (not ALIGN/CONT): exit to NORMAL, emit it, update last_prim. Same-code primitive also exits.
  - Unknown K dword: code_err, stay in CONT_ACTIVE.
- link_up low, synchronous:
  - next edge forces NORMAL, last_prim invalid, rx_valid/align_det/code_err 0;
  - err_cnt cleared unless C_HOLD_ON_LINKDOWN=1;
  - inputs ignored while low.
- Reset mid-CONT: immediately NORMAL with outputs 0.
- err_cnt saturation: pulses continue after err_cnt reaches all-ones; the count holds.

Test Plan:
- Reset/idle: host_rst pulse, link_up=0, random inputs -> all outputs 0 for 20 cycles.
- Decode sweep: link_up=1, each of the 18 table dwords with charisk 0001 -> next cycle:
  - 17 non-ALIGN entries give rx_valid=1, matching rx_prim code 1..17 (CONT only after a prior primitive);
  - ALIGN gives align_det=1, rx_valid=0.
- CONT expansion: feed HOLD, HOLD, CONT, 5 random data dwords, ALIGN, 2 data, R_IP ->
  - 2x HOLD, then 8 cycles of rx_prim=4 with cont_active=1 (ALIGN cycle rx_valid=0, align_det=1);
  - then rx_prim=11 with cont_active=0.
- Data pass: SOF, 12345678, DEADBEEF (charisk 0) -> rx_prim=14, then rx_is_prim=0 with those exact dwords, 1-cycle latency.
- Errors: charisk 0010; dword 0000007C/0001; CONT straight after reset -> 3 code_err pulses, err_cnt=3, no rx_valid. Force err_cnt near max (C_ERR_CNT_W=4) with 20 errors -> saturates at 15.
- Link drop: link_up low during CONT_ACTIVE -> cont_active=0 next cycle, err_cnt=0 (C_HOLD_ON_LINKDOWN=0). Subsequent CONT -> code_err.
